// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side memory for the single-cycle MIPS core: word-addressed RAM plus a
//   small I/O region (cycle counter, TX FIFO with valid/ready drain, STATUS).
//
//   Build option: define DMEM_CYCLE_COUNTER_EN to build the cycle counter.
//   Without it, CYCLE reads as 0 and CYCLE writes are ignored.
//
//   Ports
//     clk, reset   : clock, synchronous active-high reset
//     memwrite     : core write strobe
//     dataadr      : byte address (bit 31 selects I/O, bits [1:0] ignored)
//     writedata    : store data
//     readdata     : combinational load data (pre-edge state)
//     tx_valid/tx_data/tx_ready : FIFO head toward the external consumer
//
//   I/O map (dataadr[3:2]): 0 CYCLE, 1 TXDATA, 2 STATUS, 3 reserved
//   STATUS = {16'b0, count[7:0], 5'b0, overflow, full, empty}
module data_mem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // ---------------- decode ----------------
  logic          io_sel;
  logic [1:0]    io_idx;
  logic [AW-1:0] ram_idx;
  logic          wr_tx, wr_st;

  assign io_sel  = dataadr[31];
  assign io_idx  = dataadr[3:2];
  assign ram_idx = dataadr[AW+1:2];
  assign wr_tx   = memwrite & io_sel & (io_idx == 2'd1);
  assign wr_st   = memwrite & io_sel & (io_idx == 2'd2);

  // Upper address bits alias by design; fold them into a sink.
  logic unused_dataadr;
  assign unused_dataadr = ^dataadr;

  // ---------------- RAM ----------------
  // Not reset, and written even during reset.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && !io_sel) mem_q[ram_idx] <= writedata;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cyc_val;
`ifdef DMEM_CYCLE_COUNTER_EN
  logic        wr_cyc;
  logic [31:0] cyc_q, cyc_d;

  assign wr_cyc = memwrite & io_sel & (io_idx == 2'd0);
  // A load replaces the increment for that cycle.
  assign cyc_d  = wr_cyc ? writedata : cyc_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  // ---------------- TX FIFO ----------------
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push_ok;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : fifo_q[rptr_q];
  assign pop      = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a full push is still taken.
  assign push_ok  = wr_tx & (!full | pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (wr_tx && full && !pop) ovf_d = 1'b1;
    if (wr_st)                 ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_q[wptr_q] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // ---------------- read mux ----------------
  logic [7:0]  cnt8;
  logic [31:0] status;

  assign cnt8   = 8'(cnt_q);
  assign status = {16'b0, cnt8, 5'b0, ovf_q, full, empty};

  always_comb begin
    readdata = '0;
    if (!io_sel) begin
      readdata = mem_q[ram_idx];
    end else begin
      case (io_idx)
        2'd0:    readdata = cyc_val;
        2'd2:    readdata = status;
        default: readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif
  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_TX  = 32'h8000_0004;
  localparam logic [31:0] A_ST  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset, memwrite, tx_ready, tx_valid;
  logic [31:0] dataadr, writedata, readdata, tx_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard of words expected on the TX port, plus a model occupancy.
  logic [31:0] sb [$];
  int          mcount = 0;

  data_mem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; dataadr = a;
    @(negedge clk);
    chk(tag, readdata, exp);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while ((sb.size() != 0 || tx_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", sb.size(), 0);
    chk("txv_after_drain", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  // TX monitor/model: sampled mid-cycle, predicts the next edge.
  initial begin
    bit pop, push, acc;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      chk("txv", {31'b0, tx_valid}, (mcount != 0) ? 32'd1 : 32'd0);
      if (reset) begin
        sb.delete();
        mcount = 0;
      end else begin
        pop = tx_ready && (mcount > 0);
        if (pop) begin
          if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("txd", tx_data, e);
          end
        end
        push = memwrite && dataadr[31] && (dataadr[3:2] == 2'd1);
        acc  = push && ((mcount < FIFO_DEPTH) || pop);
        if (acc) sb.push_back(writedata);
        mcount = mcount + int'(acc) - int'(pop);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; tx_ready = 1'b0;
    dataadr = '0; writedata = '0;
    tick(); tick();
    // reset state
    chk("rst_txv", {31'b0, tx_valid}, 32'd0);
    chk("rst_txd", tx_data, 32'd0);
    rd("rst_status", A_ST, 32'h1);
    rd("rst_cyc", A_CYC, 32'h0);

    // counter: 10 edges after reset release
    reset = 1'b0;
    repeat (10) tick();
    rd("cyc10", A_CYC, CYC_EN ? 32'd10 : 32'd0);
    wr(A_CYC, 32'hFFFF_FFFF);
    rd("cyc_load", A_CYC, CYC_EN ? 32'hFFFF_FFFF : 32'd0);
    rd("cyc_wrap", A_CYC, 32'd0);

    // RAM write/read, alias, read-during-write
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram", 32'h10, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h10 + 4 * RAM_WORDS, 32'hDEAD_BEEF);
    memwrite = 1'b1; dataadr = 32'h10; writedata = 32'h1234_5678;
    @(negedge clk);
    chk("ram_rdw_old", readdata, 32'hDEAD_BEEF);
    tick();
    memwrite = 1'b0;
    rd("ram_rdw_new", 32'h10, 32'h1234_5678);
    wr(32'h4, 32'h0BAD_F00D);
    rd("ram_other", 32'h4, 32'h0BAD_F00D);
    rd("ram_keep", 32'h10, 32'h1234_5678);

    // push latency into empty FIFO
    wr(A_TX, 32'hA5);
    chk("lat_txv", {31'b0, tx_valid}, 32'd1);
    chk("lat_txd", tx_data, 32'hA5);
    drain();

    // FIFO order
    for (int i = 1; i <= 4; i++) wr(A_TX, i);
    rd("st_full", A_ST, 32'h402);
    drain();
    rd("st_empty", A_ST, 32'h1);

    // overflow: 5 dropped, sticky until STATUS write
    for (int i = 1; i <= 4; i++) wr(A_TX, i);
    wr(A_TX, 32'd5);
    rd("st_ovf", A_ST, 32'h406);
    rd("st_ovf_sticky", A_ST, 32'h406);
    wr(A_ST, 32'h0);
    rd("st_ovf_clr", A_ST, 32'h402);
    drain();

    // full push with simultaneous pop
    for (int i = 11; i <= 14; i++) wr(A_TX, i);
    tx_ready = 1'b1;
    wr(A_TX, 32'd9);
    rd("st_fullpop", A_ST, 32'h402);
    drain();
    rd("st_after_fullpop", A_ST, 32'h1);

    // reset mid-drain, with a RAM write during the reset cycle
    for (int i = 21; i <= 23; i++) wr(A_TX, i);
    reset = 1'b1; memwrite = 1'b1; dataadr = 32'h20; writedata = 32'hCAFE_F00D;
    tick();
    reset = 1'b0; memwrite = 1'b0;
    chk("rst2_txv", {31'b0, tx_valid}, 32'd0);
    rd("rst2_cyc", A_CYC, 32'd0);
    rd("rst2_status", A_ST, 32'h1);
    rd("rst2_ram", 32'h20, 32'hCAFE_F00D);
    rd("io3", 32'h8000_000C, 32'd0);
    rd("txdata_rd", A_TX, 32'd0);
    chk("sb_final", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the single-cycle MIPS core. It answers the core's `memwrite`, `dataadr`, `writedata` and `readdata` data port with word-addressed RAM and a small memory-mapped I/O region. The I/O region holds a free-running cycle counter and a transmit FIFO that drains to an external valid/ready consumer. It sits beside the core at the top level, in place of a bare data RAM.

## Interface
- `RAM_WORDS`, default 64: number of 32-bit RAM words; must be a power of 2.
- `FIFO_DEPTH`, default 4: number of TX FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `memwrite`  in  1: write strobe from the core.
- `dataadr`  in  32: byte address from the core (`aluout`); bits [1:0] are ignored.
- `writedata`  in  32: store data from the core.
- `readdata`  out  32: load data to the core; combinational.
- `tx_valid`  out  1: FIFO head is valid.
- `tx_data`  out  32: FIFO head word.
- `tx_ready`  in  1: consumer accepts the head.

## Operation
- **Region decode**
  - `dataadr[31]`=0: RAM.
  - `dataadr[31]`=1: I/O.
- **RAM**
  - Index = `dataadr[log2(RAM_WORDS)+1:2]`; upper bits are ignored, so the RAM aliases.
  - Write on the clock edge when `memwrite`=1.
  - Contents are not affected by reset.
- **I/O map** (index = `dataadr[3:2]`, other I/O bits ignored)
  - 0, CYCLE: read returns the counter. Write loads `writedata`.
  - 1, TXDATA: write pushes `writedata` into the FIFO. Read returns 0.
  - 2, STATUS: read returns {16'b0, count[7:0], 5'b0, overflow, full, empty}. A write of any value clears `overflow`.
  - 3: read returns 0; writes are ignored.
- **Cycle counter**
  - Increments by 1 every cycle.
  - Wraps from 0xFFFFFFFF to 0.
  - A write in a given cycle loads `writedata` exactly, with no increment that cycle.
- **FIFO**
  - Pop occurs when `tx_valid` & `tx_ready`.
  - Push occurs on a TXDATA write.
  - `tx_valid` = !empty; `tx_data` = head entry.
- **FIFO boundary rules**
  - Push while full with no pop: data is dropped, `overflow` is set (sticky), and count is unchanged.
  - Push while full with a simultaneous pop: the push is accepted and count is unchanged.
  - Push while empty: the pop cannot occur (`tx_valid`=0); count becomes 1.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Idle reads**: when `memwrite`=0, no state changes other than the counter and the FIFO pop.

## Timing
- **`readdata`**: purely combinational from `dataadr` and current state, valid in the same cycle, as the single-cycle core requires.
- **Read-during-write**
  - Same-cycle `readdata` shows the pre-edge value (old RAM word, old counter, old STATUS).
  - The new value is visible the next cycle.
- **Reset values**
  - Counter = 0, FIFO empty, `overflow` = 0.
  - `tx_valid` = 0, `tx_data` = 0 (empty head reads as 0).
  - `readdata` follows the decode of the reset state.
- **Reset asserted mid-transfer**: the FIFO is flushed and pending entries are lost. A write in the reset cycle is ignored for I/O state; a RAM write still occurs.
- **Push latency**: a pushed word appears on `tx_valid`/`tx_data` one cycle after the write edge when the FIFO was empty.
- **STATUS after a pop**: count drops in the cycle following the accepting edge.

## Configuration
- **`DMEM_CYCLE_COUNTER_EN` defined**: the cycle counter is implemented as described above.
- **Undefined**
  - No counter register is built.
  - CYCLE reads return 0 and writes to CYCLE are ignored.
  - The RAM, FIFO and STATUS are unchanged.

## Test plan
- **RAM write/read**: write 0xDEADBEEF to 0x00000010, then read 0x00000010 → 0xDEADBEEF. Read 0x00000010 + 4·`RAM_WORDS` → 0xDEADBEEF (alias).
- **Counter**: deassert reset, wait 10 cycles, read CYCLE (0x80000000) → 10. Write 0xFFFFFFFF, then read on the next two cycles → 0xFFFFFFFF, then 0x00000000.
- **FIFO order**
  - Hold `tx_ready`=0 and write 1, 2, 3, 4 to 0x80000004; STATUS → 0x00000402.
  - Raise `tx_ready`; `tx_data` shows 1, 2, 3, 4 on consecutive cycles, then `tx_valid`=0 and STATUS → 0x00000001.
- **Overflow**
  - Fill the FIFO with `tx_ready`=0, then write 5; STATUS → 0x00000406.
  - Write STATUS; STATUS → 0x00000402. The drain yields 1..4 only.
- **Full push with simultaneous pop**: FIFO full and `tx_ready`=1 while writing 9; count stays 4, `overflow` stays 0, and 9 emerges last.
- **Reset mid-drain**: with 3 entries queued, assert `reset` for 1 cycle → `tx_valid`=0, STATUS → 0x00000001, CYCLE → 0.
